clock_set_ctrl: RTL and testbench

- Sequencing controller for the minute/hour clock datapath (mod-60 minute counter and 12/24-h hour counter with AM/PM).
- In RUN, forwards the timebase minute tick to the minute counter.
- In SET_HOUR and SET_MIN, blocks the tick and turns button presses into single-cycle increment pulses, with auto-repeat while a button is held.
- Also drives the display blink and the field-select indicators.

---
 rtl/clock_set_ctrl_pkg.sv | 19 +
 rtl/clock_set_ctrl_if.sv | 24 ++
 rtl/clock_set_ctrl_key_repeat.sv | 76 +++++++
 rtl/clock_set_ctrl.sv | 126 ++++++++++++
 tb/tb_clock_set_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and default timing constants for the clock set controller.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_e;

  localparam int unsigned DEF_REPEAT_DELAY = 500;
  localparam int unsigned DEF_REPEAT_RATE  = 100;
  localparam int unsigned DEF_BLINK_HALF   = 250;
  localparam int unsigned DEF_TIMEOUT      = 5000;

  function automatic logic isSetState(input state_e s);
    return (s == ST_SET_HOUR) || (s == ST_SET_MIN);
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button, tick and display signals between the clock set controller and its surroundings.
interface clock_set_ctrl_if;

  logic tick_in;
  logic btn_sel;
  logic btn_inc;
  logic min_inc;
  logic hour_inc;
  logic running;
  logic sel_hour;
  logic sel_min;
  logic blink;

  modport master (
    output tick_in, btn_sel, btn_inc,
    input  min_inc, hour_inc, running, sel_hour, sel_min, blink
  );

  modport slave (
    input  tick_in, btn_sel, btn_inc,
    output min_inc, hour_inc, running, sel_hour, sel_min, blink
  );

endinterface

// File: rtl/clock_set_ctrl_key_repeat.sv
// Rising-edge detector with delay/rate auto-repeat; one registered pulse per press or repeat.
module key_repeat #(
  parameter int unsigned DELAY = 500,
  parameter int unsigned RATE  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic enable,
  input  logic clear,
  output logic pulse
);

  localparam int unsigned MAXV = (DELAY > RATE) ? DELAY : RATE;
  localparam int unsigned CW   = $clog2(MAXV + 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(RATE - 1);

  logic          btnPrev_q;
  logic          armed_q;
  logic          active_q, active_d;
  logic          repeating_q, repeating_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] limit;
  logic          rise;

  // armed_q suppresses a false edge when the button is already held as reset releases
  assign rise  = btn & ~btnPrev_q & armed_q;
  assign limit = repeating_q ? RATE_LAST : DELAY_LAST;
  assign pulse = pulse_q;

  always_comb begin
    pulse_d     = 1'b0;
    cnt_d       = cnt_q;
    active_d    = active_q;
    repeating_d = repeating_q;
    if (!enable || clear || !btn) begin
      cnt_d       = '0;
      active_d    = 1'b0;
      repeating_d = 1'b0;
    end else if (rise) begin
      pulse_d     = 1'b1;
      cnt_d       = '0;
      active_d    = 1'b1;
      repeating_d = 1'b0;
    end else if (active_q) begin
      if (cnt_q == limit) begin
        pulse_d     = 1'b1;
        cnt_d       = '0;
        repeating_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btnPrev_q   <= 1'b0;
      armed_q     <= 1'b0;
      active_q    <= 1'b0;
      repeating_q <= 1'b0;
      pulse_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      btnPrev_q   <= btn;
      armed_q     <= 1'b1;
      active_q    <= active_d;
      repeating_q <= repeating_d;
      pulse_q     <= pulse_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set-hour/set-minute sequencer with increment auto-repeat and field blink.
// Optional SET_TIMEOUT_EN adds an idle timeout that returns a set state to RUN.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int unsigned BLINK_HALF   = DEF_BLINK_HALF
`ifdef SET_TIMEOUT_EN
  , parameter int unsigned TIMEOUT    = DEF_TIMEOUT
`endif
) (
  input logic clk,
  input logic rst,
  clock_set_ctrl_if.slave ctrl
);

  localparam int unsigned BW = $clog2(BLINK_HALF + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  state_e        state_q, state_d;
  logic          selPrev_q;
  logic          selArmed_q;
  logic          selRise;
  logic          setState;
  logic          incPulse;
  logic          timeoutHit;
  logic [BW-1:0] blinkCnt_q, blinkCnt_d;
  logic          blink_q, blink_d;

  assign selRise  = ctrl.btn_sel & ~selPrev_q & selArmed_q;
  assign setState = isSetState(state_q);

  // A select press in the same cycle as an increment press clears the repeater, dropping the increment
  key_repeat #(
    .DELAY (REPEAT_DELAY),
    .RATE  (REPEAT_RATE)
  ) u_incRepeat (
    .clk    (clk),
    .rst    (rst),
    .btn    (ctrl.btn_inc),
    .enable (setState),
    .clear  (selRise),
    .pulse  (incPulse)
  );

`ifdef SET_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          idleNow;

  assign idleNow    = setState & ~selRise & ~ctrl.btn_inc;
  assign timeoutHit = idleNow && (idle_q == TIMEOUT_LAST);

  always_comb begin
    idle_d = idle_q + TW'(1);
    if (!idleNow || timeoutHit) begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (selRise) begin
      case (state_q)
        ST_RUN:      state_d = ST_SET_HOUR;
        ST_SET_HOUR: state_d = ST_SET_MIN;
        ST_SET_MIN:  state_d = ST_RUN;
        default:     state_d = ST_RUN;
      endcase
    end else if (timeoutHit) begin
      state_d = ST_RUN;
    end
  end

  // Blink restarts high on every state change and on every increment pulse
  always_comb begin
    blinkCnt_d = blinkCnt_q + BW'(1);
    blink_d    = blink_q;
    if (!setState || (state_d != state_q) || incPulse) begin
      blinkCnt_d = '0;
      blink_d    = 1'b1;
    end else if (blinkCnt_q == BLINK_LAST) begin
      blinkCnt_d = '0;
      blink_d    = ~blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      selPrev_q  <= 1'b0;
      selArmed_q <= 1'b0;
      blinkCnt_q <= '0;
      blink_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      selPrev_q  <= ctrl.btn_sel;
      selArmed_q <= 1'b1;
      blinkCnt_q <= blinkCnt_d;
      blink_q    <= blink_d;
    end
  end

  assign ctrl.running  = (state_q == ST_RUN);
  assign ctrl.sel_hour = (state_q == ST_SET_HOUR);
  assign ctrl.sel_min  = (state_q == ST_SET_MIN);
  assign ctrl.blink    = (state_q == ST_RUN) ? 1'b1 : blink_q;
  assign ctrl.min_inc  = (state_q == ST_RUN) ? ctrl.tick_in
                                             : ((state_q == ST_SET_MIN) & incPulse);
  assign ctrl.hour_inc = (state_q == ST_SET_HOUR) & incPulse;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl; the timeout phase depends on SET_TIMEOUT_EN.
module tb_clock_set_ctrl;

  typedef struct {
    int cycle;
    bit isHour;
  } pulse_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  pulse_t expQ[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(
    .REPEAT_DELAY (10),
    .REPEAT_RATE  (4),
    .BLINK_HALF   (8)
`ifdef SET_TIMEOUT_EN
    , .TIMEOUT    (20)
`endif
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus.slave)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic tick, input logic sel, input logic inc, input int n);
    bus.tick_in = tick;
    bus.btn_sel = sel;
    bus.btn_inc = inc;
    step(n);
  endtask

  task automatic expectPulse(input int at, input bit isHour);
    pulse_t p;
    p.cycle  = at;
    p.isHour = isHour;
    expQ.push_back(p);
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // select press: one cycle high then low, leaving the new state visible on return
  task automatic pressSel(input logic inc);
    applyStimulus(1'b0, 1'b1, inc, 1);
    applyStimulus(1'b0, 1'b0, inc, 1);
  endtask

  // Monitor: pops one expected pulse whenever the DUT presents an increment
  always @(negedge clk) begin
    pulse_t e;
    while (expQ.size() > 0 && expQ[0].cycle < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL missed_pulse: no increment at cycle %0d, expected hour=%0b (now %0d)",
               expQ[0].cycle, expQ[0].isHour, cyc);
      void'(expQ.pop_front());
    end
    if (bus.min_inc || bus.hour_inc) begin
      checks++;
      if (bus.min_inc && bus.hour_inc) begin
        errors++;
        $display("[TB] FAIL both_pulses: min_inc=1 hour_inc=1 at cycle %0d, expected one", cyc);
      end else if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_pulse: hour=%0b at cycle %0d, expected none", bus.hour_inc, cyc);
      end else begin
        e = expQ.pop_front();
        if (e.cycle != cyc || e.isHour != bus.hour_inc) begin
          errors++;
          $display("[TB] FAIL pulse_match: got cycle %0d hour=%0b, expected cycle %0d hour=%0b",
                   cyc, bus.hour_inc, e.cycle, e.isHour);
        end
      end
    end
  end

  initial begin
    int k;
    int p;
    bus.tick_in = 1'b0;
    bus.btn_sel = 1'b0;
    bus.btn_inc = 1'b0;

    // reset values
    step(3);
    checkOutput("reset_running", bus.running, 1'b1);
    checkOutput("reset_sel_hour", bus.sel_hour, 1'b0);
    checkOutput("reset_sel_min", bus.sel_min, 1'b0);
    checkOutput("reset_blink", bus.blink, 1'b1);
    checkOutput("reset_min_inc", bus.min_inc, 1'b0);
    checkOutput("reset_hour_inc", bus.hour_inc, 1'b0);
    rst = 1'b1;
    step(2);

    // RUN: ticks pass straight through, btn_inc ignored
    for (int i = 0; i < 3; i++) begin
      expectPulse(cyc, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    checkOutput("run_running", bus.running, 1'b1);
    checkOutput("run_blink", bus.blink, 1'b1);

    // SET_HOUR: single press, blink timing, ticks discarded
    pressSel(1'b0);
    checkOutput("sethour_sel_hour", bus.sel_hour, 1'b1);
    checkOutput("sethour_running", bus.running, 1'b0);
    checkOutput("sethour_entry_blink", bus.blink, 1'b1);
    k = cyc;
    expectPulse(k + 1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    p = k + 1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8);
    checkOutput("blink_before_wrap", bus.blink, 1'b1);
    step(1);
    checkOutput("blink_after_wrap", bus.blink, 1'b0);
    step(8);
    checkOutput("blink_second_wrap", bus.blink, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
    end
    if (p != k + 1) $display("[TB] note: unexpected cycle bookkeeping");

    // SET_MIN: held button, offsets 1,11,15,19,23,27,31
    pressSel(1'b0);
    checkOutput("setmin_sel_min", bus.sel_min, 1'b1);
    checkOutput("setmin_entry_blink", bus.blink, 1'b1);
    k = cyc;
    expectPulse(k + 1, 1'b0);
    for (int off = 11; off <= 31; off += 4) expectPulse(k + off, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 31);
    applyStimulus(1'b0, 1'b0, 1'b0, 10);

    // simultaneous select and increment edges: state moves, no pulse
    pressSel(1'b0);
    checkOutput("back_to_run", bus.running, 1'b1);
    pressSel(1'b0);
    checkOutput("again_sel_hour", bus.sel_hour, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 14);
    checkOutput("simul_sel_min", bus.sel_min, 1'b1);
    bus.btn_inc = 1'b0;
    k = cyc;

`ifdef SET_TIMEOUT_EN
    step(19);
    checkOutput("timeout_not_yet", bus.sel_min, 1'b1);
    step(1);
    checkOutput("timeout_running", bus.running, 1'b1);
`else
    step(1000);
    checkOutput("no_timeout_sel_min", bus.sel_min, 1'b1);
    pressSel(1'b0);
    checkOutput("manual_running", bus.running, 1'b1);
`endif
    expectPulse(cyc, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);

    // reset while holding btn_inc in SET_HOUR
    pressSel(1'b0);
    checkOutput("rst_pre_sel_hour", bus.sel_hour, 1'b1);
    k = cyc;
    expectPulse(k + 1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 5);
    rst = 1'b0;
    step(1);
    checkOutput("rst_mid_running", bus.running, 1'b1);
    checkOutput("rst_mid_sel_hour", bus.sel_hour, 1'b0);
    checkOutput("rst_mid_blink", bus.blink, 1'b1);
    step(2);
    rst = 1'b1;
    step(3);
    checkOutput("rst_after_running", bus.running, 1'b1);
    pressSel(1'b1);
    checkOutput("rst_held_sel_hour", bus.sel_hour, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 15);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain: %0d pulses outstanding, expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
